exu_muldiv: RTL
===============

# exu_muldiv

Multi-cycle RV32M multiply/divide unit attached beside the single-cycle execute stage. Accepts one M-extension operation at a time through a valid/ready handshake, computes it iteratively (shift-add multiply, restoring divide), stalls the front end through `hold_o`, and emits a one-cycle register-writeback pulse. It is parametrised in operand width and replaces the combinational `*` and `/` operators in the execute stage.

## Interface
- `XLEN`, 32: operand/result width; must be a power of 2 and at least 8.
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous active-low reset.
- `req_valid_i` input 1: an M-extension operation is present in the execute stage (opcode 0110011, funct7 0000001).
- `req_ready_o` output 1: the unit can accept an operation this cycle.
- `funct3_i` input 3: operation select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rd_i` input 5: destination register.
- `rs1_i` input XLEN: rs1 operand value.
- `rs2_i` input XLEN: rs2 operand value.
- `flush_i` input 1: abort any operation in flight, for example on a jump.
- `hold_o` output 1: stall the fetch/decode/execute pipeline.
- `resp_valid_o` output 1: single-cycle writeback strobe.
- `resp_rd_o` output 5: writeback address.
- `resp_data_o` output XLEN: writeback data.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE
  - `req_ready_o` = 1.
  - On `req_valid_i` & !`flush_i`: latch the operands, `funct3`, and `rd`.
  - If the operation is a special case, go directly to DONE. Otherwise go to CALC with the counter set to XLEN.
- CALC
  - One iteration per cycle; the counter decrements.
  - When the counter reaches 1, the final iteration completes and the FSM goes to DONE.
- DONE
  - `resp_valid_o` = 1 for exactly one cycle, carrying the result.
  - Next state is always IDLE.
- Operand conditioning:
  - Signed operands (MULH: both; MULHSU: rs1 only; DIV/REM: both) are converted to magnitudes.
  - Products are negated when the operand signs differ.
  - Quotients are negated when the operand signs differ.
  - Remainders take the sign of the dividend.
- Multiply: 2·XLEN-bit accumulator.
  - MUL returns the low XLEN bits.
  - MULH, MULHSU, and MULHU return the high XLEN bits.
- Divide: restoring algorithm with an (XLEN+1)-bit partial remainder.
- Special cases, resolved at accept with 1-cycle latency:
  - Divide by zero: DIV returns all-ones; DIVU returns 2^XLEN−1; REM and REMU return rs1.
  - Signed overflow (rs1 = −2^(XLEN−1), rs2 = −1): DIV returns rs1; REM returns 0.
- `hold_o` = (state==CALC) | (state==IDLE & `req_valid_i` & !`flush_i`).
  - Deasserted in DONE, so the instruction leaves the execute stage in the same cycle as writeback.
- `flush_i`, in any state:
  - Next state is IDLE.
  - `resp_valid_o` is forced to 0 in that cycle and the following one.
  - Flush takes priority over a simultaneous request.
- Iteration counter width: $clog2(XLEN)+1.

## Timing
- Reset values, applied asynchronously:
  - State IDLE, counter 0, all latched operands 0.
  - `resp_valid_o` 0, `resp_rd_o` 0, `resp_data_o` 0.
  - `req_ready_o` 1; `hold_o` 0 while `req_valid_i` is 0.
- Latency, measured as the number of rising edges after the accept edge until the cycle in which `resp_valid_o` is high:
  - Iterative path: XLEN+1. For XLEN=32, a request accepted at edge 0 responds in the cycle after edge 33.
  - Special case: 1.
- `resp_data_o` and `resp_rd_o` are registered. They hold their last value after the `resp_valid_o` pulse.
- No backpressure on the response; the register file always accepts it.
- Back-to-back operations: the next request is accepted in the IDLE cycle after DONE, giving a minimum spacing of XLEN+2 cycles.
- Reset asserted mid-operation: the operation is dropped immediately and no response is produced.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL, MULH, MULHSU, and MULHU compute their full product in a single CALC cycle using a combinational 2·XLEN multiplier.
  - Multiply latency is 2.
  - Divide behaviour is unchanged.
- Not defined:
  - Multiplies use the XLEN-cycle shift-add path.
  - No `*` operator is present in the synthesised logic.

## Test plan
- MUL: rs1=7, rs2=0xFFFFFFFD (−3), XLEN=32 → `resp_data_o`=0xFFFFFFEB, `resp_valid_o` 33 cycles after accept (2 with `MULDIV_FAST_MUL_EN`). `hold_o` high from the accept cycle through the last CALC cycle.
- MULHU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH on the same operands → 0x00000000. MULHSU with rs1=0xFFFFFFFF (−1), rs2=2 → 0xFFFFFFFF.
- Special cases, each must respond 1 cycle after accept:
  - DIVU: rs1=0x1234, rs2=0 → 0xFFFFFFFF.
  - REM: rs1=0x1234, rs2=0 → 0x1234.
  - DIV: rs1=0x80000000, rs2=0xFFFFFFFF → 0x80000000.
- Sign rules:
  - DIV −7 / 2 → 0xFFFFFFFD.
  - REM −7 % 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 % 7 → 2.
- Flush: start DIVU, assert `flush_i` at cycle 10 → no `resp_valid_o`, `req_ready_o`=1 the next cycle. A new request accepted then completes correctly.
- Reset: assert `rst_n`=0 mid-CALC → all outputs return to reset values immediately. After release, no stale `resp_valid_o` is produced.

Source files
------------

// File: rtl/exu_muldiv.sv
// exu_muldiv: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN to compute multiplies with a single-cycle combinational product.
module exu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            hold_o,
    output logic            resp_valid_o,
    output logic [4:0]      resp_rd_o,
    output logic [XLEN-1:0] resp_data_o
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam int W2 = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              spc_q, spc_d;
    logic              resp_valid_q, resp_valid_d;
    logic [4:0]        resp_rd_q, resp_rd_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;

    logic              is_div, s1, s2, sgn1, sgn2, div0, ovf, spc;
    logic [XLEN-1:0]   mag1, mag2, spc_res, quo, rmd, res;
    logic [XLEN:0]     mul_sum, div_rem, div_try;
    logic [W2-1:0]     prod;

    assign is_div  = funct3_i[2];
    assign s1      = funct3_i == 3'b001 || funct3_i == 3'b010 || (is_div && !funct3_i[0]);
    assign s2      = funct3_i == 3'b001 || (is_div && !funct3_i[0]);
    assign sgn1    = s1 && rs1_i[XLEN-1];
    assign sgn2    = s2 && rs2_i[XLEN-1];
    assign mag1    = sgn1 ? -rs1_i : rs1_i;
    assign mag2    = sgn2 ? -rs2_i : rs2_i;
    assign div0    = is_div && rs2_i == '0;
    assign ovf     = is_div && !funct3_i[0] && rs1_i == {1'b1, {(XLEN-1){1'b0}}} && rs2_i == '1;
    assign spc     = div0 || ovf;
    assign spc_res = div0 ? (funct3_i[1] ? rs1_i : '1) : (funct3_i[1] ? '0 : rs1_i);

    // acc holds {high partial, multiplier} for multiply and {remainder, quotient} for divide
    assign mul_sum = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign div_rem = acc_q[W2-1:XLEN-1];
    assign div_try = div_rem - {1'b0, b_q};

    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rmd  = neg_q ? -acc_q[W2-1:XLEN] : acc_q[W2-1:XLEN];
    assign res  = spc_q ? acc_q[XLEN-1:0] :
                  !op_q[2] ? (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[W2-1:XLEN]) :
                  op_q[1] ? rmd : quo;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        rd_d         = rd_q;
        b_d          = b_q;
        acc_d        = acc_q;
        neg_d        = neg_q;
        spc_d        = spc_q;
        resp_valid_d = 1'b0;
        resp_rd_d    = resp_rd_q;
        resp_data_d  = resp_data_q;
        if (flush_i) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (req_valid_i) begin
                op_d    = funct3_i;
                rd_d    = rd_i;
                b_d     = mag2;
                neg_d   = (is_div && funct3_i[1]) ? sgn1 : sgn1 ^ sgn2;
                spc_d   = spc;
                acc_d   = {{XLEN{1'b0}}, spc ? spc_res : mag1};
                cnt_d   = spc ? '0 : CW'(XLEN);
                state_d = spc ? DONE : CALC;
            end
        end else if (state_q == CALC) begin
`ifdef MULDIV_FAST_MUL_EN
            if (!op_q[2]) begin
                acc_d   = W2'(acc_q[XLEN-1:0]) * W2'(b_q);
                cnt_d   = '0;
                state_d = DONE;
            end else
`endif
            begin
                acc_d   = op_q[2] ? (div_try[XLEN] ? {acc_q[W2-2:0], 1'b0}
                                                   : {div_try[XLEN-1:0], acc_q[XLEN-2:0], 1'b1})
                                  : {mul_sum, acc_q[XLEN-1:1]};
                cnt_d   = cnt_q - CW'(1);
                state_d = cnt_q == CW'(1) ? DONE : CALC;
            end
        end else begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            resp_rd_d    = rd_q;
            resp_data_d  = res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            rd_q         <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            neg_q        <= 1'b0;
            spc_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rd_q    <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            neg_q        <= neg_d;
            spc_q        <= spc_d;
            resp_valid_q <= resp_valid_d;
            resp_rd_q    <= resp_rd_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign req_ready_o  = state_q == IDLE;
    assign hold_o       = state_q == CALC || (state_q == IDLE && req_valid_i && !flush_i);
    assign resp_valid_o = resp_valid_q && !flush_i;
    assign resp_rd_o    = resp_rd_q;
    assign resp_data_o  = resp_data_q;
endmodule
